// File: rtl/mbox_subreg_wr_arb.sv
// Round-robin arbiter for the software write port of a mailbox register bank.
// Hold-grant locking is built only when MBOX_SUBREG_WR_ARB_LOCK_EN is defined.
module mbox_subreg_wr_arb #(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = 8,
    parameter int DW       = 32,
    parameter int AW       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*AW-1:0] addr_i,
    input  logic [NUM_REQ*DW-1:0] wdata_i,
    input  logic [NUM_REQ-1:0]    lock_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [NUM_REQ-1:0]    err_o,
    output logic [NUM_REGS-1:0]   reg_we_o,
    output logic [DW-1:0]         reg_wd_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  gnt;
    logic [PW-1:0]       win;
    logic [PW-1:0]       idx;
    logic                any_gnt;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_data;
    logic                addr_ok;

    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [NUM_REGS-1:0] we_q, we_d;
    logic [DW-1:0]       wd_q, wd_d;

`ifdef MBOX_SUBREG_WR_ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic          hold;

    // The owner dropping lock_i releases the restriction in that same cycle.
    assign hold = (state_q == LOCKED) && lock_i[owner_q];

    always_comb begin
        elig = req_i;
        if (hold) begin
            elig = '0;
            elig[owner_q] = req_i[owner_q];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            UNLOCKED: begin
                if (any_gnt && lock_i[win]) begin
                    state_d = LOCKED;
                    owner_d = win;
                end
            end
            LOCKED: begin
                if (!lock_i[owner_q]) begin
                    state_d = UNLOCKED;
                    if (any_gnt && lock_i[win]) begin
                        state_d = LOCKED;
                        owner_d = win;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign elig = req_i;
`endif

    always_comb begin
        gnt     = '0;
        win     = ptr_q;
        idx     = ptr_q;
        any_gnt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr_q) + 1 + i) % NUM_REQ);
            if (!any_gnt && elig[idx]) begin
                any_gnt = 1'b1;
                win     = idx;
            end
        end
        if (rst_i) begin
            any_gnt = 1'b0;
        end
        if (any_gnt) begin
            gnt[win] = 1'b1;
        end
    end

    assign win_addr = addr_i[int'(win)*AW +: AW];
    assign win_data = wdata_i[int'(win)*DW +: DW];
    assign addr_ok  = int'(win_addr) < NUM_REGS;
    assign ptr_d    = any_gnt ? win : ptr_q;

    // Stage holds the decoded write so the bank sees a clean registered we/wd.
    always_comb begin
        ack_d = gnt;
        err_d = '0;
        we_d  = '0;
        wd_d  = wd_q;
        if (any_gnt) begin
            if (addr_ok) begin
                we_d = NUM_REGS'(1) << win_addr;
                wd_d = win_data;
            end else begin
                err_d = gnt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PTR_RST;
            ack_q <= '0;
            err_q <= '0;
            we_q  <= '0;
            wd_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            ack_q <= ack_d;
            err_q <= err_d;
            we_q  <= we_d;
            wd_q  <= wd_d;
        end
    end

    // A stage write caught by reset is dropped rather than shown for a cycle.
    assign gnt_o    = gnt;
    assign ack_o    = ack_q & {NUM_REQ{~rst_i}};
    assign err_o    = err_q & {NUM_REQ{~rst_i}};
    assign reg_we_o = we_q & {NUM_REGS{~rst_i}};
    assign reg_wd_o = wd_q;

endmodule

// File: tb/tb_mbox_subreg_wr_arb.sv
// Scoreboard bench for mbox_subreg_wr_arb with NUM_REQ=2, NUM_REGS=8.
module tb_mbox_subreg_wr_arb;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_i = '0;
    logic [1:0]  lock_i = '0;
    logic [7:0]  addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [1:0]  gnt_o, ack_o, err_o;
    logic [7:0]  reg_we_o;
    logic [31:0] reg_wd_o;

`ifdef MBOX_SUBREG_WR_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    mbox_subreg_wr_arb dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .lock_i(lock_i),
        .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o),
        .reg_we_o(reg_we_o), .reg_wd_o(reg_wd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [7:0]  we;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    int          nchk = 0;
    int          nerr = 0;
    logic        m_ptr = 1'b1;
    logic        m_locked = 1'b0;
    logic        m_owner = 1'b0;
    logic [31:0] m_wd = '0;
    logic [1:0]  egnt;
    exp_t        got;
    bit          have;

    task automatic drive(input logic r, input logic [1:0] rq,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] lk);
        logic [1:0]  el;
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        exp_t        e;
        @(posedge clk_i);
        #1;
        rst_i = r; req_i = rq; addr_i = {a1, a0};
        wdata_i = {d1, d0}; lock_i = lk;
        egnt = 2'b00;
        w = 1'b0;
        if (r) begin
            if (sb.size() > 0) begin
                sb[0].ack = '0; sb[0].err = '0; sb[0].we = '0;
            end
            m_ptr = 1'b1; m_locked = 1'b0; m_owner = 1'b0; m_wd = '0;
            sb.push_back('0);
            return;
        end
        el = rq;
        if (LOCK_EN && m_locked && lk[m_owner])
            el = rq & (2'b01 << m_owner);
        if (el[~m_ptr]) begin
            w = ~m_ptr; egnt = 2'b01 << w;
        end else if (el[m_ptr]) begin
            w = m_ptr; egnt = 2'b01 << w;
        end
        e = '0;
        e.wd = m_wd;
        if (egnt != 2'b00) begin
            a = w ? a1 : a0;
            d = w ? d1 : d0;
            e.ack = egnt;
            if (a < 4'd8) begin
                e.we = 8'h01 << a; e.wd = d; m_wd = d;
            end else begin
                e.err = egnt;
            end
            m_ptr = w;
        end
        if (LOCK_EN && !(m_locked && lk[m_owner])) begin
            m_locked = 1'b0;
            if (egnt != 2'b00 && lk[w]) begin
                m_locked = 1'b1; m_owner = w;
            end
        end
        sb.push_back(e);
    endtask

    task automatic sample();
        @(negedge clk_i);
        have = sb.size() > 1;
        if (have) got = sb.pop_front();
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 4'd0, 4'd0, '0, '0, 2'b00);
        sample();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b11, 4'd1, 4'd2, 32'h11, 32'h22, 2'b00);
            sample();
            nchk++;
            if ({gnt_o, ack_o, reg_we_o, reg_wd_o} !== 44'h0) begin
                nerr++;
                $display("FAIL reset_hold gnt=%b ack=%b we=%h wd=%h want all 0",
                         gnt_o, ack_o, reg_we_o, reg_wd_o);
            end
        end
        drive(1'b0, 2'b11, 4'd1, 4'd2, 32'h11, 32'h22, 2'b00);
        sample();
        nchk++;
        if (gnt_o !== 2'b01 || gnt_o !== egnt) begin
            nerr++;
            $display("FAIL reset_first_gnt got=%b want=01", gnt_o);
        end
        if (have) begin
            nchk++;
            if ({ack_o, err_o, reg_we_o, reg_wd_o} !== got) begin
                nerr++;
                $display("FAIL reset_out got=%h want=%h",
                         {ack_o, err_o, reg_we_o, reg_wd_o}, got);
            end
        end
        idle();
    endtask

    task automatic test_single();
        drive(1'b0, 2'b10, 4'd0, 4'd3, 32'h0, 32'hDEADBEEF, 2'b00);
        sample();
        nchk++;
        if (gnt_o !== 2'b10 || gnt_o !== egnt) begin
            nerr++;
            $display("FAIL single_gnt got=%b want=10", gnt_o);
        end
        idle();
        nchk++;
        if (ack_o !== 2'b10 || err_o !== 2'b00 ||
            reg_we_o !== 8'h08 || reg_wd_o !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL single_out ack=%b err=%b we=%h wd=%h want 10 00 08 deadbeef",
                     ack_o, err_o, reg_we_o, reg_wd_o);
        end
        nchk++;
        if (have && {ack_o, err_o, reg_we_o, reg_wd_o} !== got) begin
            nerr++;
            $display("FAIL single_sb got=%h want=%h",
                     {ack_o, err_o, reg_we_o, reg_wd_o}, got);
        end
    endtask

    task automatic test_contention();
        logic [1:0] want[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 5; i++) begin
            if (i < 4)
                drive(1'b0, 2'b11, 4'(i), 4'(i + 4),
                      $urandom, $urandom, 2'b00);
            else
                drive(1'b0, 2'b00, 4'd0, 4'd0, '0, '0, 2'b00);
            sample();
            if (i < 4) begin
                nchk++;
                if (gnt_o !== want[i] || gnt_o !== egnt) begin
                    nerr++;
                    $display("FAIL contention_gnt%0d got=%b want=%b",
                             i, gnt_o, want[i]);
                end
            end
            if (have) begin
                nchk++;
                if ({ack_o, err_o, reg_we_o, reg_wd_o} !== got) begin
                    nerr++;
                    $display("FAIL contention_out%0d got=%h want=%h", i,
                             {ack_o, err_o, reg_we_o, reg_wd_o}, got);
                end
            end
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] wd_before;
        wd_before = reg_wd_o;
        drive(1'b0, 2'b01, 4'd9, 4'd0, 32'hBAD0BAD0, '0, 2'b00);
        sample();
        nchk++;
        if (gnt_o !== 2'b01 || gnt_o !== egnt) begin
            nerr++;
            $display("FAIL bad_gnt got=%b want=01", gnt_o);
        end
        idle();
        nchk++;
        if (ack_o !== 2'b01 || err_o !== 2'b01 ||
            reg_we_o !== 8'h00 || reg_wd_o !== wd_before) begin
            nerr++;
            $display("FAIL bad_out ack=%b err=%b we=%h wd=%h want 01 01 00 %h",
                     ack_o, err_o, reg_we_o, reg_wd_o, wd_before);
        end
        nchk++;
        if (have && {ack_o, err_o, reg_we_o, reg_wd_o} !== got) begin
            nerr++;
            $display("FAIL bad_sb got=%h want=%h",
                     {ack_o, err_o, reg_we_o, reg_wd_o}, got);
        end
    endtask

    task automatic test_reset_midop();
        drive(1'b0, 2'b01, 4'd2, 4'd0, 32'hCAFE0001, '0, 2'b00);
        sample();
        nchk++;
        if (gnt_o !== egnt) begin
            nerr++;
            $display("FAIL midop_gnt got=%b want=%b", gnt_o, egnt);
        end
        drive(1'b1, 2'b00, 4'd0, 4'd0, '0, '0, 2'b00);
        sample();
        nchk++;
        if (ack_o !== 2'b00 || reg_we_o !== 8'h00) begin
            nerr++;
            $display("FAIL midop_drop ack=%b we=%h want 00 00", ack_o, reg_we_o);
        end
        drive(1'b0, 2'b11, 4'd5, 4'd6, 32'h5, 32'h6, 2'b00);
        sample();
        nchk++;
        if (ack_o !== 2'b00 || reg_we_o !== 8'h00 ||
            ({ack_o, err_o, reg_we_o, reg_wd_o} !== got)) begin
            nerr++;
            $display("FAIL midop_after ack=%b we=%h wd=%h want 00 00 0",
                     ack_o, reg_we_o, reg_wd_o);
        end
        nchk++;
        if (gnt_o !== 2'b01 || gnt_o !== egnt) begin
            nerr++;
            $display("FAIL midop_ptr gnt=%b want=01", gnt_o);
        end
        idle();
    endtask

    task automatic test_lock();
        logic [1:0] want[4];
        logic [1:0] lk;
        if (LOCK_EN) want = '{2'b01, 2'b01, 2'b01, 2'b10};
        else         want = '{2'b01, 2'b10, 2'b01, 2'b10};
        drive(1'b1, 2'b00, 4'd0, 4'd0, '0, '0, 2'b00);
        sample();
        for (int i = 0; i < 5; i++) begin
            lk = (i < 3) ? 2'b01 : 2'b00;
            if (i < 4)
                drive(1'b0, 2'b11, 4'(i), 4'(7 - i),
                      $urandom, $urandom, lk);
            else
                drive(1'b0, 2'b00, 4'd0, 4'd0, '0, '0, 2'b00);
            sample();
            if (i < 4) begin
                nchk++;
                if (gnt_o !== want[i] || gnt_o !== egnt) begin
                    nerr++;
                    $display("FAIL lock_gnt%0d got=%b want=%b",
                             i, gnt_o, want[i]);
                end
            end
            if (have) begin
                nchk++;
                if ({ack_o, err_o, reg_we_o, reg_wd_o} !== got) begin
                    nerr++;
                    $display("FAIL lock_out%0d got=%h want=%h", i,
                             {ack_o, err_o, reg_we_o, reg_wd_o}, got);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_bad_addr();
        test_reset_midop();
        test_lock();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
